// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: keeps the PC, issues one word fetch at a
// time over a valid/ready channel, buffers returned words with their PCs in
// a 2-entry FIFO for decode, and applies execute-stage redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        redirect_valid,
    input  logic        redirect_sel,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] immext,
    input  logic [31:0] aluresult,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_pc_reg, req_pc_next;
    logic        drop_reg, drop_next;
    logic        misaligned_reg, misaligned_next;
    logic        live_reg;
    logic [1:0]  count_reg, count_next;
    logic        head_reg, head_next;

    logic        handshake;
    logic        redir;
    logic        push;
    logic        pop;
    logic        flush;
    logic        wr_idx;
    logic [31:0] target;
    logic [31:0] entry_pc   [2];
    logic [31:0] entry_data [2];

    // Redirect target: branch/jal adds the immediate to the redirecting PC,
    // jalr clears bit 0 of the ALU sum.
    assign target = redirect_sel ? (aluresult & ~32'h1) : (redirect_pc + immext);
    assign redir  = redirect_valid && (state_reg != HALT);

    // live_reg holds requests off until the first clock edge after reset
    // release, so nothing is requested while reset is asserted.
    assign imem_req_valid = live_reg && (state_reg == RUN) && (count_reg != 2'd2);
    assign imem_addr      = pc_reg;
    assign handshake      = imem_req_valid && imem_req_ready;

    assign instr_valid   = (count_reg != 2'd0);
    assign pop           = instr_valid && instr_ready;
    assign wr_idx        = head_reg ^ count_reg[0];
    assign instr         = entry_data[head_reg];
    assign instr_pc      = entry_pc[head_reg];
    assign instr_pcplus4 = entry_pc[head_reg] + 32'd4;
    assign misaligned    = misaligned_reg;

    // Marks the design live from the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) live_reg <= 1'b0;
        else        live_reg <= 1'b1;
    end

    // Control state, PC, in-flight tracking and FIFO occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            req_pc_reg     <= RESET_PC;
            drop_reg       <= 1'b0;
            misaligned_reg <= 1'b0;
            count_reg      <= 2'd0;
            head_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_pc_reg     <= req_pc_next;
            drop_reg       <= drop_next;
            misaligned_reg <= misaligned_next;
            count_reg      <= count_next;
            head_reg       <= head_next;
        end
    end

    // Next-state logic: fetch sequencing first, then redirect overrides it.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_pc_next     = req_pc_reg;
        drop_next       = drop_reg;
        misaligned_next = misaligned_reg;
        push            = 1'b0;
        flush           = 1'b0;

        case (state_reg)
            RUN: begin
                if (handshake) begin
                    req_pc_next = pc_reg;
                    pc_next     = pc_reg + 32'd4;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    push       = !drop_reg;
                    drop_next  = 1'b0;
                    state_next = RUN;
                end
            end
            default: ;
        endcase

        if (redir) begin
            flush = 1'b1;
            push  = 1'b0;
            if (target[1:0] != 2'b00) begin
                misaligned_next = 1'b1;
                drop_next       = 1'b0;
                state_next      = HALT;
            end else begin
                pc_next = target;
                if (state_reg == RUN) begin
                    // A request accepted in this same cycle is now stale.
                    drop_next = handshake;
                end else begin
                    // Same-cycle response is discarded via push = 0 above;
                    // otherwise the response still to come must be dropped.
                    drop_next = !imem_resp_valid;
                end
            end
        end

        if (flush) begin
            count_next = 2'd0;
            head_next  = 1'b0;
        end else begin
            count_next = count_reg + {1'b0, push} - {1'b0, pop};
            head_next  = head_reg ^ pop;
        end
    end

    // FIFO storage, one register pair per entry, written at the tail slot.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [31:0] pc_reg_e;
            logic [31:0] data_reg_e;

            // Capture the returning word and its PC when this slot is the tail.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pc_reg_e   <= '0;
                    data_reg_e <= '0;
                end else if (push && (wr_idx == 1'(gi))) begin
                    pc_reg_e   <= req_pc_reg;
                    data_reg_e <= imem_resp_data;
                end
            end

            assign entry_pc[gi]   = pc_reg_e;
            assign entry_data[gi] = data_reg_e;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a small latency-programmable memory
// responder folded into the per-cycle tick task.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        redirect_valid;
    logic        redirect_sel;
    logic [31:0] redirect_pc;
    logic [31:0] immext;
    logic [31:0] aluresult;
    logic        misaligned;

    int n_checks;
    int n_fail;

    // memory model state
    int          mem_lat;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic        hs;
    logic [31:0] hs_addr;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pcplus4   (instr_pcplus4),
        .redirect_valid  (redirect_valid),
        .redirect_sel    (redirect_sel),
        .redirect_pc     (redirect_pc),
        .immext          (immext),
        .aluresult       (aluresult),
        .misaligned      (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; advances one clock and models the memory response.
    task automatic tick();
        #1;
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_addr;
        @(posedge clk);
        #1;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = hs_addr;
            pend_cnt  = mem_lat;
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend            = 1'b0;
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_of(pend_addr);
            end
        end
        $display("t=%0t req_v=%0b addr=%h resp_v=%0b iv=%0b ipc=%h mis=%0b",
                 $time, imem_req_valid, imem_addr, imem_resp_valid, instr_valid, instr_pc, misaligned);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mem_lat  = 1;
        pend     = 1'b0;
        pend_cnt = 0;
        pend_addr = '0;
        reset           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_sel    = 1'b0;
        redirect_pc     = '0;
        immext          = '0;
        aluresult       = '0;

        // Reset state
        #11;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_misaligned", misaligned, 0);
        chk("rst_addr", imem_addr, 32'h100);
        #1;
        reset = 1'b1;
        tick();

        // Sequential fetch with zero-wait memory
        for (int k = 0; k < 3; k++) begin
            chk("seq_req_valid", imem_req_valid, 1);
            chk("seq_addr", imem_addr, 32'h100 + 32'(4 * k));
            tick();
            chk("seq_wait_no_req", imem_req_valid, 0);
            tick();
            chk("seq_instr_valid", instr_valid, 1);
            chk("seq_instr_pc", instr_pc, 32'h100 + 32'(4 * k));
            chk("seq_pcplus4", instr_pcplus4, 32'h104 + 32'(4 * k));
            chk("seq_instr", instr, word_of(32'h100 + 32'(4 * k)));
        end

        // Decode stall: FIFO fills to 2, requests stop
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 1) chk("stall_no_req", imem_req_valid, 0);
        end
        chk("stall_head_pc", instr_pc, 32'h108);
        chk("stall_valid", instr_valid, 1);
        instr_ready = 1'b1;
        tick();
        chk("drain1_pc", instr_pc, 32'h10C);
        chk("drain1_instr", instr, word_of(32'h10C));
        chk("drain1_req", imem_req_valid, 1);
        chk("drain1_addr", imem_addr, 32'h110);
        tick();
        tick();
        chk("drain2_pc", instr_pc, 32'h110);
        chk("drain2_valid", instr_valid, 1);

        // Branch redirect while waiting, response 3 cycles after acceptance
        instr_ready = 1'b0;
        mem_lat     = 3;
        tick();
        chk("br_pre_valid", instr_valid, 1);
        redirect_valid = 1'b1;
        redirect_sel   = 1'b0;
        redirect_pc    = 32'h200;
        immext         = 32'hFFFF_FFF0;
        tick();
        chk("br_flush", instr_valid, 0);
        chk("br_wait_req", imem_req_valid, 0);
        tick();
        chk("br_resp_arrives", imem_resp_valid, 1);
        chk("br_wait_req2", imem_req_valid, 0);
        tick();
        chk("br_dropped", instr_valid, 0);
        chk("br_req_valid", imem_req_valid, 1);
        chk("br_target", imem_addr, 32'h1F0);
        instr_ready = 1'b1;
        mem_lat     = 1;

        // jalr redirect coinciding with a request handshake
        redirect_valid = 1'b1;
        redirect_sel   = 1'b1;
        aluresult      = 32'h305;
        redirect_pc    = 32'h0;
        immext         = 32'h1;
        tick();
        chk("jalr_wait", imem_req_valid, 0);
        tick();
        chk("jalr_dropped", instr_valid, 0);
        chk("jalr_req_valid", imem_req_valid, 1);
        chk("jalr_target", imem_addr, 32'h304);
        tick();
        tick();
        chk("jalr_instr_pc", instr_pc, 32'h304);
        chk("jalr_instr", instr, word_of(32'h304));

        // Misaligned branch target halts fetch
        redirect_valid = 1'b1;
        redirect_sel   = 1'b0;
        redirect_pc    = 32'h200;
        immext         = 32'h2;
        tick();
        chk("mis_flag", misaligned, 1);
        chk("mis_instr_valid", instr_valid, 0);
        chk("mis_req", imem_req_valid, 0);
        tick();
        chk("mis_late_resp_iv", instr_valid, 0);
        chk("mis_req2", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1E0;
        immext         = 32'h10;
        tick();
        chk("mis_ignore_redir_flag", misaligned, 1);
        chk("mis_ignore_redir_req", imem_req_valid, 0);
        tick();
        chk("mis_still_no_req", imem_req_valid, 0);
        chk("mis_still_no_iv", instr_valid, 0);

        // Asynchronous reset clears the halt without a clock edge
        reset           = 1'b0;
        pend            = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        chk("areset_misaligned", misaligned, 0);
        chk("areset_req", imem_req_valid, 0);
        chk("areset_iv", instr_valid, 0);
        chk("areset_addr", imem_addr, 32'h100);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_req", imem_req_valid, 1);
        chk("post_reset_addr", imem_addr, 32'h100);

        // PC wrap-around at the top of the address space
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_sel   = 1'b1;
        aluresult      = 32'hFFFF_FFFD;
        tick();
        chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req", imem_req_valid, 1);
        imem_req_ready = 1'b1;
        tick();
        tick();
        chk("wrap_next_addr", imem_addr, 32'h0000_0000);
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", instr_pcplus4, 32'h0000_0000);
        chk("wrap_instr", instr, word_of(32'hFFFF_FFFC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
